// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel type and fetch FSM state encoding.
package vga_pkg;

  localparam int unsigned H_ACTIVE     = 800;
  localparam int unsigned V_ACTIVE     = 600;
  localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  // 800x600@72 timing, shared with the timing generator
  localparam int unsigned H_FRONT = 56;
  localparam int unsigned H_SYNC  = 120;
  localparam int unsigned H_BACK  = 64;
  localparam int unsigned H_TOTAL = 1040;
  localparam int unsigned V_FRONT = 37;
  localparam int unsigned V_SYNC  = 6;
  localparam int unsigned V_BACK  = 23;
  localparam int unsigned V_TOTAL = 666;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Prefetch FIFO between the framebuffer read port and the pixel output register.
module vga_pixel_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [11:0]      push_data,
  input  logic             pop,
  output logic [11:0]      head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  rgb444_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  // Storage is flops, so the head entry comes straight from a register
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rgb444_t'(push_data);
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Streams framebuffer pixels into a prefetch FIFO and drives registered VGA colour.
module vga_pixel_fetch
  import vga_pkg::rgb444_t, vga_pkg::fetch_state_t, vga_pkg::IDLE, vga_pkg::FETCH, vga_pkg::DRAIN;
#(
  parameter int unsigned H_ACTIVE      = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE      = vga_pkg::V_ACTIVE,
  parameter int unsigned ADDR_W        = 19,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter logic [11:0] UNDERFLOW_RGB = 12'h000
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RESET_N,
  input  logic              frame_start,
  input  logic              pixel_en,
  output logic              fb_req,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic              fb_gnt,
  input  logic              fb_rvalid,
  input  logic [11:0]       fb_rdata,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              underflow,
  output logic              frame_fetched
);

  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1;
  // Stale responses from an aborted frame; one frame start per frame keeps this small
  localparam int unsigned DISC_W       = CNT_W + 1;
  localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  fetch_state_t      state;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  out_nxt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W:0]    credit_sum;
  logic [DISC_W-1:0] discard;
  logic [11:0]       fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              grant;
  logic              last_grant;
  logic              rsp_drop;
  logic              rsp_push;
  logic              pop_ok;
  logic              credit_ok;
  rgb444_t           pix_q;

  assign grant      = fb_req && fb_gnt;
  assign last_grant = grant && (fb_addr == LAST_ADDR);
  assign rsp_drop   = fb_rvalid && (discard != '0);
  assign rsp_push   = fb_rvalid && (discard == '0) && (outstanding != '0);
  assign pop_ok     = pixel_en && !fifo_empty;
  assign out_nxt    = outstanding + CNT_W'(grant) - CNT_W'(rsp_push);
  assign count_nxt  = frame_start ? '0 : fifo_count + CNT_W'(rsp_push) - CNT_W'(pop_ok);
  // Buffered plus in-flight must stay below depth so no response can overflow the FIFO
  assign credit_sum = {1'b0, count_nxt} + {1'b0, out_nxt};
  assign credit_ok  = credit_sum < (CNT_W + 1)'(FIFO_DEPTH);

  assign VGA_R = pix_q.r;
  assign VGA_G = pix_q.g;
  assign VGA_B = pix_q.b;

  vga_pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (MAX10_CLK1_50),
    .rst_n    (RESET_N),
    .flush    (frame_start),
    .push     (rsp_push),
    .push_data(fb_rdata),
    .pop      (pixel_en),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Fetch FSM: address generation, request credit and in-flight bookkeeping
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      fb_addr       <= '0;
      fb_req        <= 1'b0;
      outstanding   <= '0;
      discard       <= '0;
      frame_fetched <= 1'b0;
    end else if (frame_start) begin
      state         <= FETCH;
      fb_addr       <= '0;
      fb_req        <= 1'b1;
      outstanding   <= '0;
      discard       <= discard - DISC_W'(rsp_drop) + DISC_W'(out_nxt);
      frame_fetched <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      discard     <= discard - DISC_W'(rsp_drop);
      fb_req      <= 1'b0;
      case (state)
        IDLE: ;
        FETCH: begin
          if (last_grant) begin
            state <= DRAIN;
          end else begin
            if (grant) fb_addr <= fb_addr + ADDR_W'(1);
            fb_req <= credit_ok;
          end
        end
        DRAIN: begin
          if (out_nxt == '0) begin
            state         <= IDLE;
            frame_fetched <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: one pixel per active-video strobe, blank otherwise
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pix_q     <= '0;
      underflow <= 1'b0;
    end else begin
      if (!pixel_en)        pix_q <= '0;
      else if (!fifo_empty) pix_q <= rgb444_t'(fifo_head);
      else                  pix_q <= rgb444_t'(UNDERFLOW_RGB);
      if (frame_start)                   underflow <= 1'b0;
      else if (pixel_en && fifo_empty)   underflow <= 1'b1;
    end
  end

  // A response with nothing in flight or pending discard breaks the read protocol
  assert property (@(posedge MAX10_CLK1_50) disable iff (!RESET_N)
    !(fb_rvalid && (discard == '0) && (outstanding == '0)));

  // Credit accounting must never let a response land in a full FIFO
  assert property (@(posedge MAX10_CLK1_50) disable iff (!RESET_N)
    !(rsp_push && fifo_full && !pop_ok));

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch with a reduced frame size.
module tb_vga_pixel_fetch;

  localparam int unsigned H_ACT  = 20;
  localparam int unsigned V_ACT  = 6;
  localparam int unsigned FRAME  = H_ACT * V_ACT;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 19;
  localparam logic [11:0] UF_RGB = 12'hF0F;

  logic          MAX10_CLK1_50;
  logic          RESET_N;
  logic          frame_start;
  logic          pixel_en;
  logic          fb_req;
  logic [AW-1:0] fb_addr;
  logic          fb_gnt;
  logic          fb_rvalid;
  logic [11:0]   fb_rdata;
  logic [3:0]    VGA_R;
  logic [3:0]    VGA_G;
  logic [3:0]    VGA_B;
  logic          underflow;
  logic          frame_fetched;

  vga_pixel_fetch #(
    .H_ACTIVE     (H_ACT),
    .V_ACTIVE     (V_ACT),
    .ADDR_W       (AW),
    .FIFO_DEPTH   (DEPTH),
    .UNDERFLOW_RGB(UF_RGB)
  ) dut (
    .MAX10_CLK1_50(MAX10_CLK1_50),
    .RESET_N      (RESET_N),
    .frame_start  (frame_start),
    .pixel_en     (pixel_en),
    .fb_req       (fb_req),
    .fb_addr      (fb_addr),
    .fb_gnt       (fb_gnt),
    .fb_rvalid    (fb_rvalid),
    .fb_rdata     (fb_rdata),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B),
    .underflow    (underflow),
    .frame_fetched(frame_fetched)
  );

  initial MAX10_CLK1_50 = 1'b0;
  always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  // Framebuffer memory model: in-order responses tagged with the frame they belong to
  typedef struct {
    logic [11:0] data;
    int unsigned due;
    int unsigned epoch;
  } rsp_t;

  typedef struct {
    bit          pe;
    logic [11:0] rgb;
    bit          uf;
  } vec_t;

  rsp_t        rsp_q[$];
  logic [11:0] ref_fifo[$];
  int unsigned cyc;
  int unsigned epoch;
  int unsigned grants_cur;
  int unsigned last_due;
  int unsigned lat_min;
  int unsigned lat_max;
  logic [AW-1:0] last_addr;
  logic [11:0] salt;
  logic [11:0] salt_next;
  logic [11:0] exp_vga;
  bit          started;
  bit          exp_uf;
  bit          exp_fetched;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned inflight();
    int unsigned n;
    n = 0;
    foreach (rsp_q[i]) if (rsp_q[i].epoch == epoch) n++;
    return n;
  endfunction

  task automatic model_reset();
    rsp_q.delete();
    ref_fifo.delete();
    epoch++;
    grants_cur  = 0;
    started     = 1'b0;
    exp_vga     = 12'h000;
    exp_uf      = 1'b0;
    exp_fetched = 1'b0;
    last_due    = cyc;
  endtask

  // One clock: drive inputs, advance the reference model, compare after the edge
  task automatic cycle(input bit fs, input bit pe, input bit gnt);
    bit          rv;
    bit          rv_cur;
    logic [11:0] rd;
    int unsigned due;
    bit          exp_req;
    exp_req = started && (grants_cur < FRAME) &&
              ((int'(ref_fifo.size()) + int'(inflight())) < int'(DEPTH));
    check("fb_req", 32'(fb_req), 32'(exp_req));
    rv = 1'b0; rv_cur = 1'b0; rd = 12'h000;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rv     = 1'b1;
      rd     = rsp_q[0].data;
      rv_cur = (rsp_q[0].epoch == epoch);
      rsp_q.delete(0);
    end
    frame_start = fs;
    pixel_en    = pe;
    fb_gnt      = gnt;
    fb_rvalid   = rv;
    fb_rdata    = rd;
    if (fb_req && gnt) begin
      check("fb_addr", 32'(fb_addr), grants_cur);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due  = due;
      last_addr = fb_addr;
      rsp_q.push_back('{data: fb_addr[11:0] ^ salt, due: due, epoch: epoch});
      grants_cur++;
    end
    if (!pe)                      exp_vga = 12'h000;
    else if (ref_fifo.size() > 0) exp_vga = ref_fifo.pop_front();
    else begin
      exp_vga = UF_RGB;
      exp_uf  = 1'b1;
    end
    if (rv_cur) ref_fifo.push_back(rd);
    if (fs) begin
      ref_fifo.delete();
      epoch++;
      grants_cur = 0;
      started    = 1'b1;
      exp_uf     = 1'b0;
      salt       = salt_next;
    end
    exp_fetched = started && (grants_cur == FRAME) && (inflight() == 0);
    @(posedge MAX10_CLK1_50);
    #1;
    cyc++;
    check("vga_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_vga));
    check("underflow", 32'(underflow), 32'(exp_uf));
    check("frame_fetched", 32'(frame_fetched), 32'(exp_fetched));
    check("fifo_bound", 32'(ref_fifo.size() <= DEPTH), 32'd1);
  endtask

  vec_t vecs[32];

  initial begin
    int unsigned pops;
    int unsigned budget;
    bit          fs;
    checks = 0; errors = 0; cyc = 0; epoch = 0;
    salt = 12'h000; salt_next = 12'h000; last_addr = '0;
    lat_min = 2; lat_max = 2;
    RESET_N = 1'b0; frame_start = 1'b0; pixel_en = 1'b0;
    fb_gnt = 1'b0; fb_rvalid = 1'b0; fb_rdata = 12'h000;
    model_reset();

    // Underflow drain table: 16 buffered pixels, grants blocked, blanking every 4th slot
    pops = 0;
    for (int i = 0; i < 32; i++) begin
      vecs[i].pe = (i % 4 != 3);
      if (!vecs[i].pe)      vecs[i].rgb = 12'h000;
      else if (pops < 16)   vecs[i].rgb = 12'(pops);
      else                  vecs[i].rgb = UF_RGB;
      if (vecs[i].pe) pops++;
      vecs[i].uf = (pops > 16);
    end

    // Power-on reset
    repeat (3) @(posedge MAX10_CLK1_50);
    #1;
    check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
    check("rst_req", 32'(fb_req), 32'h0);
    check("rst_addr", 32'(fb_addr), 32'h0);
    check("rst_uf", 32'(underflow), 32'h0);
    check("rst_fetched", 32'(frame_fetched), 32'h0);
    RESET_N = 1'b1;

    // Reset mid-FETCH with three reads outstanding and a visible underflow colour
    lat_min = 10; lat_max = 10;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    check("grants_before_reset", grants_cur, 3);
    cycle(1'b0, 1'b1, 1'b0);
    RESET_N = 1'b0;
    #1;
    check("async_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
    check("async_rst_req", 32'(fb_req), 32'h0);
    check("async_rst_uf", 32'(underflow), 32'h0);
    check("async_rst_addr", 32'(fb_addr), 32'h0);
    @(posedge MAX10_CLK1_50);
    @(posedge MAX10_CLK1_50);
    #1;
    cyc += 2;
    model_reset();
    RESET_N = 1'b1;
    repeat (10) cycle(1'b0, 1'b0, 1'b1);

    // Fill to the credit limit with rdata = addr, then drain past empty
    lat_min = 2; lat_max = 2; salt_next = 12'h000;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (24) cycle(1'b0, 1'b0, 1'b1);
    check("grants_at_credit_limit", grants_cur, 16);
    check("req_at_credit_limit", 32'(fb_req), 32'h0);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, vecs[i].pe, 1'b0);
      check("tbl_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(vecs[i].rgb));
      check("tbl_uf", 32'(underflow), 32'(vecs[i].uf));
    end
    repeat (8) cycle(1'b0, 1'b0, 1'b0);
    check("uf_sticky", 32'(underflow), 32'h1);

    // Frame restart while five reads are in flight: their data must be dropped
    lat_min = 8; lat_max = 8; salt_next = 12'hA5A;
    cycle(1'b1, 1'b0, 1'b0);
    check("uf_cleared", 32'(underflow), 32'h0);
    repeat (5) cycle(1'b0, 1'b0, 1'b1);
    check("inflight_before_restart", inflight(), 5);
    lat_min = 2; lat_max = 2; salt_next = 12'h3C3;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (26) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("first_pixel_after_restart", 32'({VGA_R, VGA_G, VGA_B}), 32'h3C3);

    // Finish the frame with continuous popping, no underflow allowed
    lat_min = 1; lat_max = 3;
    budget = 0;
    while (frame_fetched !== 1'b1 && budget < 600) begin
      cycle(1'b0, ref_fifo.size() > 0, 1'b1);
      budget++;
    end
    check("frame_done", 32'(frame_fetched), 32'h1);
    check("frame_grants", grants_cur, FRAME);
    check("last_addr", 32'(last_addr), FRAME - 1);
    check("no_underflow", 32'(underflow), 32'h0);
    repeat (5) cycle(1'b0, 1'b0, 1'b1);

    // Steady state: pop every cycle with single-cycle latency (push+pop, grant+rvalid)
    lat_min = 1; lat_max = 1; salt_next = 12'h5A5;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 1'b1);
    repeat (60) cycle(1'b0, 1'b1, 1'b1);
    check("steady_no_underflow", 32'(underflow), 32'h0);

    // Randomized traffic with occasional frame restarts
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 3000; i++) begin
      fs = ($urandom_range(299, 0) == 0);
      if (fs) salt_next = 12'($urandom);
      cycle(fs, $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Pixel source stage directly upstream of the VGA timing/output stage on the DE10-Lite.
- Streams 800x600 RGB444 pixels from the framebuffer read port into a small prefetch FIFO.
- Pops one pixel per active-video strobe from the timing generator and drives registered VGA_R/G/B.
- Replaces the hard-coded colour with framebuffer data and provides the data-ready handshake the output stage needs.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 600, active lines per frame
- ADDR_W, 19, framebuffer pixel address width (800*600 = 480000 < 2^19)
- FIFO_DEPTH, 16, prefetch FIFO entries (power of 2)
- UNDERFLOW_RGB, 12'h000, colour driven when a pop finds the FIFO empty

Ports:
- MAX10_CLK1_50  in  1  sole clock, 50 MHz, all logic on posedge
- RESET_N  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse from timing gen during vertical blank; restarts the frame
- pixel_en  in  1  active-video strobe; consume one pixel this cycle
- fb_req  out  1  read request valid
- fb_addr  out  ADDR_W  linear pixel address, row-major
- fb_gnt  in  1  request accepted this cycle when fb_req=1
- fb_rvalid  in  1  read data valid; returns in request order, any latency >= 1
- fb_rdata  in  12  {R[11:8], G[7:4], B[3:0]}
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue
- underflow  out  1  sticky; cleared only by frame_start or reset
- frame_fetched  out  1  high once all H_ACTIVE*V_ACTIVE pixels are written to the FIFO for this frame

Behaviour:
- Reset, asynchronous:
  - All outputs are 0; state IDLE.
  - addr=0, FIFO empty, outstanding=0, discard=0.
- FSM states and transitions:
  - IDLE: fb_req=0. frame_start -> FETCH.
  - FETCH: fb_req=1 iff (fifo_count + outstanding) < FIFO_DEPTH. On fb_req&fb_gnt: addr++ and outstanding++. When the grant for address H_ACTIVE*V_ACTIVE-1 occurs -> DRAIN.
  - DRAIN: fb_req=0. When outstanding reaches 0 -> IDLE with frame_fetched=1.
- frame_start in any state, highest priority:
  - Flush the FIFO (count=0), set addr=0, frame_fetched=0, underflow=0.
  - Set discard = outstanding, including a grant in that same cycle. Set outstanding=0.
  - Next state is FETCH.
- fb_rvalid handling:
  - If discard>0: discard--, data is dropped.
  - Else if outstanding>0: push to FIFO, outstanding--.
  - Else: ignore. Cannot happen under protocol; checked by assertion.
- Grant and response in the same cycle: outstanding net unchanged. The credit check uses the pre-update values.
- Credit rule guarantees no FIFO overflow. The FIFO is never pushed when full; assert this.
- Output path, 1-cycle latency from pixel_en:
  - pixel_en=1 and FIFO non-empty: pop, and next cycle drive the head pixel on VGA_R/G/B.
  - pixel_en=1 and FIFO empty: drive UNDERFLOW_RGB next cycle and set underflow.
  - pixel_en=0: drive 0 next cycle (blanking).
- Push and pop in the same cycle: allowed, count unchanged. There is no empty-FIFO bypass; a pop from an empty FIFO is an underflow even if a push occurs that cycle.
- Address is a plain binary increment. addr never exceeds H_ACTIVE*V_ACTIVE-1; no wrap inside a frame.
- fifo_count and outstanding are clog2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Package vga_pkg:
  - H_ACTIVE, V_ACTIVE, FRAME_PIXELS = H_ACTIVE*V_ACTIVE
  - rgb444_t (12-bit {r,g,b})
  - FSM state enum {IDLE, FETCH, DRAIN}
  - The timing constants shared with the timing generator (56/120/64 h porches, 37/6/23 v porches, 1040x666 totals)
- Sub-module vga_pixel_fifo:
  - Synchronous FIFO, FIFO_DEPTH x 12, registered read data.
  - Ports: push, pop, flush, count, empty, full.

Test Plan:
- Reset held low mid-FETCH with 3 requests outstanding -> RGB=0, fb_req=0, underflow=0 immediately; after release, state stays IDLE until frame_start.
- frame_start; fb_gnt always 1; rvalid 2 cycles after grant with rdata=addr[11:0]; pixel_en asserted after 16 pixels are buffered -> VGA outputs 12'h000, 001, 002, … one cycle after each pixel_en; fb_req drops when count+outstanding=16.
- Full frame with zero underflow -> exactly 480000 grants, last fb_addr=479999, frame_fetched=1 after the final rvalid, underflow stays 0.
- fb_gnt held low for 40 cycles while pixel_en runs with 16 pixels buffered -> 16 valid pixels, then UNDERFLOW_RGB from pop 17 onward, underflow=1 sticky until the next frame_start.
- frame_start while 5 responses are outstanding -> those 5 rvalids are dropped, the first pixel output afterwards equals the data for addr 0, and the FIFO never exceeds 16 entries.
- Same-cycle push+pop with FIFO at 16, and same-cycle grant+rvalid -> count stays 16, outstanding unchanged, no overflow assertion fires.
